brick_map_responder: RTL and testbench
======================================

Name: brick_map_responder

Overview:
- Owns the brick field for the Arkanoid core and answers collision queries from the ball state controller.
- The ball controller issues one query per ball turn carrying ball position and radius. This block scans the brick map and reports whether a brick was struck, which brick, and which axis to reflect. It also decrements that brick's strength.
- It exports the packed brick map to the VGA renderer, plus score and a level-cleared flag to top-level game control.

Parameters:
- MAXROW, 4, brick rows
- MAXCOL, 8, brick columns
- BLK_W, 80, brick width in pixels (MAXCOL*BLK_W <= 640)
- BLK_H, 20, brick height in pixels
- TOP, 40, y pixel of the top edge of row 0
- BONUS, 10, score added when a brick reaches strength 0

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  request to load a new level
- load_data  in  MAXROW*MAXCOL*4  initial strengths; brick (r,c) sits at bits [(r*MAXCOL+c)*4 +: 4]
- req  in  1  query request; held high until ack
- req_x  in  10  ball centre x
- req_y  in  10  ball centre y
- req_radius  in  6  ball radius
- ack  out  1  one-cycle pulse; query complete
- hit  out  1  a brick was struck
- hit_side  out  1  0 = reflect y, 1 = reflect x
- hit_row  out  2  row of struck brick
- hit_col  out  3  column of struck brick
- blocks  out  MAXROW*MAXCOL*4  current strengths, same packing as load_data
- score  out  16  accumulated score, saturating
- cleared  out  1  all strengths zero

Behaviour:
- Reset (async, reset_n=0) clears state and outputs:
  - state IDLE, blocks=0, score=0
  - ack=0, hit=0, hit_side=0, hit_row=0, hit_col=0
  - cleared=1, pending load flag=0
- States: IDLE, SCAN, UPDATE, RESP.
- IDLE:
  - If the pending load flag or load is set: blocks<=load_data, clear the flag, stay in IDLE.
  - Load has priority over req in the same cycle; req stays waiting.
  - Otherwise, if req=1: latch x, y and radius, clear hit, set index=0, go to SCAN.
- SCAN: one brick per cycle, index 0..N-1 (N=MAXROW*MAXCOL) in row-major order.
  - Work in 11-bit unsigned arithmetic.
  - Ball box: bx0=max(x-r,0), bx1=x+r, by0=max(y-r,0), by1=y+r.
  - Brick box: cx0=c*BLK_W, cx1=cx0+BLK_W-1, cy0=TOP+r*BLK_H, cy1=cy0+BLK_H-1.
  - A brick is a candidate when strength!=0 and the boxes overlap inclusively.
  - The first candidate (lowest index) is captured. Later candidates are ignored.
  - Side: 0 if cx0<=x<=cx1, else 1.
  - After index N-1, go to UPDATE. The scan always runs the full N cycles, with no early exit.
- UPDATE: if a brick was captured:
  - Decrement its strength by 1.
  - Add 1 to score, plus BONUS if the new strength is 0; saturate at 16'hFFFF.
  - Then go to RESP.
- RESP: ack=1 for exactly one cycle, then return to IDLE.
  - hit, hit_side, hit_row and hit_col are valid with ack and held until the next query is accepted.
  - hit=0 implies row, col and side are 0.
- Latency: acceptance edge k, ack high during the cycle after edge k+N+2.
- load asserted in SCAN, UPDATE or RESP sets the pending load flag. The map is replaced in the next IDLE cycle, so an in-flight query completes against the old map.
- cleared is registered and recomputed from the blocks register every cycle.
- The requester must not change req_* while req is high. The block samples them only at acceptance.
- reset_n low mid-query: the query is abandoned, no ack is produced, and the map is zeroed.

Decomposition:
- Shared game package holds:
  - geometry constants MAXROW, MAXCOL, BLK_W, BLK_H, TOP, MAXX=639, MAXY=479;
  - state encoding for IDLE/SCAN/UPDATE/RESP;
  - a brick-index-to-(row,col) helper function.
- One sub-module, brick_overlap: combinational box test for a single brick, taking latched ball parameters and index and producing candidate and side.
- The FSM, map storage and scoring stay in brick_map_responder.

Test Plan:
- Reset: blocks=0, score=0, cleared=1, ack=0. Then load with all strengths 1 -> blocks all 1 next cycle, cleared=0.
- Simple hit: all strengths 1; req x=100, y=50, r=4 -> ack exactly 34 cycles after acceptance; hit=1, row 0, col 1, side 0; brick(0,1)=0; score=11.
- Lowest index wins, x-reflect: x=162, y=50, r=4 (box overlaps col1 and col2) -> hit col 1, side 1.
- Miss: x=320, y=300, r=4 -> ack after 34 cycles; hit=0, row/col/side=0; score unchanged.
- Multi-strike: brick(2,5)=3; three queries at x=440, y=90, r=2 -> strengths 2, 1, 0; score +1, +1, +11 (total 13); cleared=1 if it was the only brick.
- Boundary and reset: load pulsed at SCAN cycle 5 -> old-map result returned, new map in place the cycle after RESP. reset_n low mid-SCAN -> no ack, state IDLE, blocks=0.

Source files
------------

// File: rtl/brick_map_responder_pkg.sv
// Shared Arkanoid brick-field definitions: geometry, responder state encoding
// and the brick index to (row, col) mapping.
package brick_map_responder_pkg;

  localparam int MAXROW = 4;
  localparam int MAXCOL = 8;
  localparam int BLK_W  = 80;
  localparam int BLK_H  = 20;
  localparam int TOP    = 40;
  localparam int MAXX   = 639;
  localparam int MAXY   = 479;

  localparam int NBRICK = MAXROW * MAXCOL;
  localparam int IDX_W  = $clog2(NBRICK);
  localparam int MAP_W  = NBRICK * 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [2:0] col;
  } brick_rc_t;

  function automatic brick_rc_t idx_to_rc(input logic [IDX_W-1:0] idx);
    brick_rc_t rc;
    rc.row = 2'(idx / MAXCOL);
    rc.col = 3'(idx % MAXCOL);
    return rc;
  endfunction

endpackage

// File: rtl/brick_map_responder_overlap.sv
// Combinational ball-box versus brick-box test for the brick at idx_i.
module brick_overlap
  import brick_map_responder_pkg::*;
(
  input  logic [9:0]       x_i,
  input  logic [9:0]       y_i,
  input  logic [5:0]       r_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [3:0]       strength_i,
  output logic             cand_o,
  output logic             side_o
);

  brick_rc_t   rc;
  logic [10:0] x11, y11, r11;
  logic [10:0] bx0, bx1, by0, by1;
  logic [10:0] cx0, cx1, cy0, cy1;
  logic        overlap;

  assign rc  = idx_to_rc(idx_i);
  assign x11 = {1'b0, x_i};
  assign y11 = {1'b0, y_i};
  assign r11 = {5'b0, r_i};

  // Ball box clamps at the left/top screen edge instead of wrapping.
  assign bx0 = (x11 >= r11) ? x11 - r11 : 11'd0;
  assign bx1 = x11 + r11;
  assign by0 = (y11 >= r11) ? y11 - r11 : 11'd0;
  assign by1 = y11 + r11;

  assign cx0 = 11'(rc.col) * 11'(BLK_W);
  assign cx1 = cx0 + 11'(BLK_W - 1);
  assign cy0 = 11'(TOP) + 11'(rc.row) * 11'(BLK_H);
  assign cy1 = cy0 + 11'(BLK_H - 1);

  assign overlap = (bx0 <= cx1) && (bx1 >= cx0) && (by0 <= cy1) && (by1 >= cy0);
  assign cand_o  = (strength_i != 4'd0) && overlap;
  // Centre inside the brick's column span means a top/bottom strike.
  assign side_o  = !((cx0 <= x11) && (x11 <= cx1));

endmodule

// File: rtl/brick_map_responder.sv
// Brick field owner: answers ball collision queries, updates strengths and score.
module brick_map_responder
  import brick_map_responder_pkg::*;
#(
  parameter int BONUS = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [MAP_W-1:0] load_data,
  input  logic             req,
  input  logic [9:0]       req_x,
  input  logic [9:0]       req_y,
  input  logic [5:0]       req_radius,
  output logic             ack,
  output logic             hit,
  output logic             hit_side,
  output logic [1:0]       hit_row,
  output logic [2:0]       hit_col,
  output logic [MAP_W-1:0] blocks,
  output logic [15:0]      score,
  output logic             cleared
);

  state_e           state_q, state_d;
  logic [MAP_W-1:0] blocks_q, blocks_d;
  logic [15:0]      score_q, score_d;
  logic             cleared_q;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             hit_q, hit_d, side_q, side_d;
  logic [1:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [IDX_W-1:0] idx_q, idx_d, hidx_q, hidx_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [5:0]       r_q, r_d;

  logic             cand, side;
  brick_rc_t        rc;
  logic [3:0]       new_str;
  logic [16:0]      sum;

  brick_overlap u_overlap (
    .x_i       (x_q),
    .y_i       (y_q),
    .r_i       (r_q),
    .idx_i     (idx_q),
    .strength_i(blocks_q[{idx_q, 2'b00} +: 4]),
    .cand_o    (cand),
    .side_o    (side)
  );

  assign rc = idx_to_rc(idx_q);

  always_comb begin
    state_d  = state_q;
    blocks_d = blocks_q;
    score_d  = score_q;
    pend_d   = pend_q;
    ack_d    = 1'b0;
    hit_d    = hit_q;
    side_d   = side_q;
    row_d    = row_q;
    col_d    = col_q;
    idx_d    = idx_q;
    hidx_d   = hidx_q;
    x_d      = x_q;
    y_d      = y_q;
    r_d      = r_q;
    new_str  = blocks_q[{hidx_q, 2'b00} +: 4] - 4'd1;
    sum      = {1'b0, score_q} + 17'd1 + ((new_str == 4'd0) ? 17'(BONUS) : 17'd0);

    case (state_q)
      ST_IDLE: begin
        if (pend_q || load) begin
          blocks_d = load_data;
          pend_d   = 1'b0;
        end else if (req && !ack_q) begin
          // req is still high during the ack cycle; it belongs to the finished query.
          x_d     = req_x;
          y_d     = req_y;
          r_d     = req_radius;
          hit_d   = 1'b0;
          side_d  = 1'b0;
          row_d   = 2'd0;
          col_d   = 3'd0;
          hidx_d  = '0;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (load) pend_d = 1'b1;
        if (cand && !hit_q) begin
          hit_d  = 1'b1;
          side_d = side;
          row_d  = rc.row;
          col_d  = rc.col;
          hidx_d = idx_q;
        end
        if (idx_q == IDX_W'(NBRICK - 1)) state_d = ST_UPDATE;
        else                             idx_d   = idx_q + 1'b1;
      end
      ST_UPDATE: begin
        if (load) pend_d = 1'b1;
        if (hit_q) begin
          blocks_d[{hidx_q, 2'b00} +: 4] = new_str;
          score_d = sum[16] ? 16'hFFFF : sum[15:0];
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (load) pend_d = 1'b1;
        ack_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      blocks_q  <= '0;
      score_q   <= '0;
      cleared_q <= 1'b1;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      hit_q     <= 1'b0;
      side_q    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      hidx_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      blocks_q  <= blocks_d;
      score_q   <= score_d;
      cleared_q <= (blocks_q == '0);
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      hit_q     <= hit_d;
      side_q    <= side_d;
      row_q     <= row_d;
      col_q     <= col_d;
      idx_q     <= idx_d;
      hidx_q    <= hidx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      r_q       <= r_d;
    end
  end

  assign ack      = ack_q;
  assign hit      = hit_q;
  assign hit_side = side_q;
  assign hit_row  = row_q;
  assign hit_col  = col_q;
  assign blocks   = blocks_q;
  assign score    = score_q;
  assign cleared  = cleared_q;

endmodule

// File: tb/tb_brick_map_responder.sv
// Directed bench for brick_map_responder with hand-computed expectations.
module tb_brick_map_responder;
  import brick_map_responder_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             load;
  logic [MAP_W-1:0] load_data;
  logic             req;
  logic [9:0]       req_x, req_y;
  logic [5:0]       req_radius;
  logic             ack, hit, hit_side;
  logic [1:0]       hit_row;
  logic [2:0]       hit_col;
  logic [MAP_W-1:0] blocks;
  logic [15:0]      score;
  logic             cleared;

  int total = 0;
  int bad   = 0;
  int lat;
  int ack_seen;
  logic [MAP_W-1:0] ones, twos, fives, exp_map;

  brick_map_responder dut (
    .clock(clock), .reset_n(reset_n), .load(load), .load_data(load_data),
    .req(req), .req_x(req_x), .req_y(req_y), .req_radius(req_radius),
    .ack(ack), .hit(hit), .hit_side(hit_side), .hit_row(hit_row), .hit_col(hit_col),
    .blocks(blocks), .score(score), .cleared(cleared)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MAP_W-1:0] setnib(input logic [MAP_W-1:0] m, input int i,
                                               input logic [3:0] v);
    logic [MAP_W-1:0] t;
    t = m;
    t[i*4 +: 4] = v;
    return t;
  endfunction

  task automatic do_load(input logic [MAP_W-1:0] v);
    @(negedge clock);
    load = 1'b1;
    load_data = v;
    @(negedge clock);
    load = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Returns #1 after the edge that raises ack; lat counts edges after acceptance.
  task automatic run_query(input logic [9:0] x, input logic [9:0] y, input logic [5:0] r,
                           input int load_at, input logic [MAP_W-1:0] ld);
    int n;
    logic got;
    @(negedge clock);
    req = 1'b1; req_x = x; req_y = y; req_radius = r;
    @(posedge clock);
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clock);
      n++;
      #1;
      load = (n == load_at);
      if (n == load_at) load_data = ld;
      if (ack) got = 1'b1;
    end
    load = 1'b0;
    lat = n;
    chk("ack_timeout", got, 1'b1);
    chk("latency", lat, 34);
  endtask

  task automatic end_query();
    @(negedge clock);
    req = 1'b0;
    @(posedge clock);
    #1;
    chk("ack_one_cycle", ack, 1'b0);
  endtask

  initial begin
    ones  = {NBRICK{4'h1}};
    twos  = {NBRICK{4'h2}};
    fives = {NBRICK{4'h5}};
    reset_n = 1'b0; load = 1'b0; load_data = '0; req = 1'b0;
    req_x = '0; req_y = '0; req_radius = '0;
    repeat (3) @(negedge clock);
    chk("rst_blocks", blocks, 0);
    chk("rst_score", score, 0);
    chk("rst_cleared", cleared, 1);
    chk("rst_ack", ack, 0);
    chk("rst_hit", {hit, hit_side, hit_row, hit_col}, 0);
    reset_n = 1'b1;

    do_load(ones);
    chk("load_blocks", blocks, ones);
    chk("load_cleared", cleared, 0);

    // Simple hit on brick (0,1)
    run_query(10'd100, 10'd50, 6'd4, 0, '0);
    chk("q1_hit", hit, 1);
    chk("q1_rowcolside", {hit_row, hit_col, hit_side}, {2'd0, 3'd1, 1'b0});
    exp_map = setnib(ones, 1, 4'h0);
    chk("q1_blocks", blocks, exp_map);
    chk("q1_score", score, 11);
    end_query();

    // Box straddles col1/col2; col1 wins and the centre is outside it
    do_load(ones);
    run_query(10'd162, 10'd50, 6'd4, 0, '0);
    chk("q2_hit", hit, 1);
    chk("q2_rowcolside", {hit_row, hit_col, hit_side}, {2'd0, 3'd1, 1'b1});
    chk("q2_score", score, 22);
    end_query();

    // Miss below the field
    run_query(10'd320, 10'd300, 6'd4, 0, '0);
    chk("miss_all", {hit, hit_side, hit_row, hit_col}, 0);
    chk("miss_score", score, 22);
    end_query();

    // Multi-strike on brick (2,5), index 21
    do_load(setnib('0, 21, 4'h3));
    chk("ms_cleared0", cleared, 0);
    run_query(10'd440, 10'd90, 6'd2, 0, '0);
    chk("ms1_rowcol", {hit, hit_row, hit_col, hit_side}, {1'b1, 2'd2, 3'd5, 1'b0});
    chk("ms1_blocks", blocks, setnib('0, 21, 4'h2));
    chk("ms1_score", score, 23);
    end_query();
    run_query(10'd440, 10'd90, 6'd2, 0, '0);
    chk("ms2_blocks", blocks, setnib('0, 21, 4'h1));
    chk("ms2_score", score, 24);
    end_query();
    run_query(10'd440, 10'd90, 6'd2, 0, '0);
    chk("ms3_blocks", blocks, 0);
    chk("ms3_score", score, 35);
    chk("ms3_cleared", cleared, 1);
    end_query();

    // Load pulsed during SCAN: query completes on the old map
    do_load(twos);
    run_query(10'd100, 10'd50, 6'd4, 5, fives);
    chk("pl_hit", {hit, hit_row, hit_col}, {1'b1, 2'd0, 3'd1});
    chk("pl_old_map", blocks, setnib(twos, 1, 4'h1));
    chk("pl_score", score, 36);
    end_query();
    chk("pl_new_map", blocks, fives);

    // Reset in the middle of a scan
    @(negedge clock);
    req = 1'b1; req_x = 10'd100; req_y = 10'd50; req_radius = 6'd4;
    repeat (11) @(posedge clock);
    #1;
    reset_n = 1'b0;
    req = 1'b0;
    #1;
    chk("mr_blocks", blocks, 0);
    chk("mr_score", score, 0);
    chk("mr_ack", ack, 0);
    @(negedge clock);
    reset_n = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ack) ack_seen++;
    end
    chk("mr_no_ack", ack_seen, 0);

    // Back in IDLE: a fresh query works normally
    do_load(ones);
    run_query(10'd100, 10'd50, 6'd4, 0, '0);
    chk("post_rst_score", score, 11);
    end_query();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
